// File: rtl/fetch_queue_pkg.sv
// Shared core types for the fetch queue: entry layout, default sizing and a small helper.
// Entries carry FQ_WIDTH-bit inst/pc fields, so instances should use WIDTH <= FQ_WIDTH.
package fetch_queue_pkg;

  localparam int FQ_WIDTH = 32;
  localparam int FQ_DEPTH = 8;

  typedef struct packed {
    logic [FQ_WIDTH-1:0] inst;
    logic [FQ_WIDTH-1:0] pc;
    logic                bp_taken;
  } fq_entry_t;

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/fq_slot_compactor.sv
// Packs the valid fetch slots into an ordered list (oldest first) plus a write count.
// Unused output entries are driven to zero so downstream views need no extra masking.
module fq_slot_compactor
  import fetch_queue_pkg::*;
#(
  parameter int WIDTH = FQ_WIDTH
) (
  input  logic [1:0]          i_valid,
  input  logic [2*WIDTH-1:0]  i_inst,
  input  logic [2*WIDTH-1:0]  i_pc,
  input  logic [1:0]          i_bpTaken,
  output logic [1:0]          o_count,
  output fq_entry_t [1:0]     o_entry
);

  fq_entry_t [1:0] w_slot;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      w_slot[k].inst     = FQ_WIDTH'(i_inst[k*WIDTH +: WIDTH]);
      w_slot[k].pc       = FQ_WIDTH'(i_pc[k*WIDTH +: WIDTH]);
      w_slot[k].bp_taken = i_bpTaken[k];
    end
  end

  // A lone slot-1 instruction moves down into position 0.
  always_comb begin
    o_entry = '0;
    o_count = popcount2(i_valid);
    if (i_valid[0]) begin
      o_entry[0] = w_slot[0];
      if (i_valid[1]) o_entry[1] = w_slot[1];
    end else if (i_valid[1]) begin
      o_entry[0] = w_slot[1];
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Two-wide fetch-to-decode instruction queue with flush and a two-entry head view.
// Optional macro FETCH_QUEUE_BYPASS_EN lets incoming fetch data appear on the view in the same cycle.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int WIDTH = FQ_WIDTH,
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 in_valid,
  input  logic [2*WIDTH-1:0]         in_inst,
  input  logic [2*WIDTH-1:0]         in_pc,
  input  logic [1:0]                 in_bp_taken,
  output logic                       in_ready,
  output logic [1:0]                 out_valid,
  output logic [2*WIDTH-1:0]         out_inst,
  output logic [2*WIDTH-1:0]         out_pc,
  output logic [1:0]                 out_bp_taken,
  input  logic [1:0]                 deq,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fq_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  logic [1:0]      w_compCount;
  fq_entry_t [1:0] w_inEntry;
  fq_entry_t [1:0] w_inAccepted;
  logic            w_canEnq;
  logic [1:0]      w_nEnq;
  fq_entry_t       w_head0;
  fq_entry_t       w_head1;
  fq_entry_t [1:0] w_view;
  logic [1:0]      w_viewValid;
  logic            w_deq0;
  logic            w_deq1;
  logic [1:0]      w_nDeq;
  logic [1:0]      w_skip;
  logic [1:0]      w_qPop;
  logic [1:0]      w_nStore;
  fq_entry_t       w_wrEntry0;

  fq_slot_compactor #(.WIDTH(WIDTH)) u_compactor (
    .i_valid   (in_valid),
    .i_inst    (in_inst),
    .i_pc      (in_pc),
    .i_bpTaken (in_bp_taken),
    .o_count   (w_compCount),
    .o_entry   (w_inEntry)
  );

  assign in_ready     = (CW'(DEPTH) - r_count) >= CW'(2);
  assign count        = r_count;
  assign w_canEnq     = in_ready & ~flush;
  assign w_nEnq       = w_canEnq ? w_compCount : 2'd0;
  assign w_inAccepted = w_canEnq ? w_inEntry : '0;
  assign w_head0      = r_mem[r_head];
  assign w_head1      = r_mem[r_head + PW'(1)];

`ifdef FETCH_QUEUE_BYPASS_EN
  logic [CW-1:0] w_avail;
  assign w_avail = r_count + CW'(w_nEnq);

  // View is the stored entries followed by whatever fetch is delivering this cycle.
  always_comb begin
    w_viewValid[0] = w_avail >= CW'(1);
    w_viewValid[1] = w_avail >= CW'(2);
    if (r_count >= CW'(2)) begin
      w_view[0] = w_head0;
      w_view[1] = w_head1;
    end else if (r_count == CW'(1)) begin
      w_view[0] = w_head0;
      w_view[1] = w_inAccepted[0];
    end else begin
      w_view[0] = w_inAccepted[0];
      w_view[1] = w_inAccepted[1];
    end
  end
`else
  always_comb begin
    w_viewValid[0] = r_count >= CW'(1);
    w_viewValid[1] = r_count >= CW'(2);
    w_view         = '0;
    if (w_viewValid[0]) w_view[0] = w_head0;
    if (w_viewValid[1]) w_view[1] = w_head1;
  end
`endif

  always_comb begin
    out_valid    = w_viewValid;
    out_inst     = '0;
    out_pc       = '0;
    out_bp_taken = '0;
    for (int k = 0; k < 2; k++) begin
      out_inst[k*WIDTH +: WIDTH] = WIDTH'(w_view[k].inst);
      out_pc[k*WIDTH +: WIDTH]   = WIDTH'(w_view[k].pc);
      out_bp_taken[k]            = w_view[k].bp_taken;
    end
  end

  // Pops beyond the stored count are taken from the bypassed entries, which then skip storage.
  always_comb begin
    w_deq0     = deq[0] & w_viewValid[0];
    w_deq1     = deq[1] & deq[0] & w_viewValid[1];
    w_nDeq     = {1'b0, w_deq0} + {1'b0, w_deq1};
    w_skip     = (CW'(w_nDeq) > r_count) ? (w_nDeq - r_count[1:0]) : 2'd0;
    w_qPop     = w_nDeq - w_skip;
    w_nStore   = w_nEnq - w_skip;
    w_wrEntry0 = (w_skip == 2'd0) ? w_inAccepted[0] : w_inAccepted[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_qPop);
      r_tail  <= r_tail + PW'(w_nStore);
      r_count <= r_count + CW'(w_nStore) - CW'(w_qPop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_nStore >= 2'd1) r_mem[r_tail] <= w_wrEntry0;
    if (w_nStore == 2'd2) r_mem[r_tail + PW'(1)] <= w_inAccepted[1];
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a queue model acts as scoreboard for the head view,
// and a vector table carries hand-derived occupancy after each edge.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  logic                 clk;
  logic                 rst;
  logic [1:0]           in_valid;
  logic [2*WIDTH-1:0]   in_inst;
  logic [2*WIDTH-1:0]   in_pc;
  logic [1:0]           in_bp_taken;
  logic                 in_ready;
  logic [1:0]           out_valid;
  logic [2*WIDTH-1:0]   out_inst;
  logic [2*WIDTH-1:0]   out_pc;
  logic [1:0]           out_bp_taken;
  logic [1:0]           deq;
  logic                 flush;
  logic [$clog2(DEPTH):0] count;

  fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_inst      (in_inst),
    .in_pc        (in_pc),
    .in_bp_taken  (in_bp_taken),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_inst     (out_inst),
    .out_pc       (out_pc),
    .out_bp_taken (out_bp_taken),
    .deq          (deq),
    .flush        (flush),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] inst;
    logic [WIDTH-1:0] pc;
    logic             bp;
  } ent_t;

  typedef struct {
    logic [1:0]  v;
    logic [31:0] p0;
    logic [31:0] p1;
    logic [1:0]  d;
    logic        f;
    int          expCount;
  } vec_t;

  ent_t modelQ[$];
  ent_t incQ[$];
  ent_t visQ[$];
  vec_t vecs[21];
  int   checks = 0;
  int   errors = 0;

  task automatic expect32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compares the whole decode-side view against the scoreboard contents in visQ.
  task automatic checkOutput(input bit expReady);
    ent_t e;
    bit   has;
    expect32("in_ready", 32'(in_ready), 32'(expReady));
    expect32("count_now", 32'(count), 32'(modelQ.size()));
    expect32("count_bound", 32'(count <= DEPTH), 32'd1);
    for (int k = 0; k < 2; k++) begin
      has = visQ.size() > k;
      e   = '{default: '0};
      if (has) e = visQ[k];
      expect32($sformatf("out_valid%0d", k), 32'(out_valid[k]), 32'(has));
      expect32($sformatf("out_pc%0d", k), out_pc[k*WIDTH +: WIDTH], e.pc);
      expect32($sformatf("out_inst%0d", k), out_inst[k*WIDTH +: WIDTH], e.inst);
      expect32($sformatf("out_bp%0d", k), 32'(out_bp_taken[k]), 32'(e.bp));
    end
  endtask

  // Drives one cycle, checks the view before the edge, then advances the model past the edge.
  task automatic applyStimulus(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                               input logic [1:0] d, input logic f);
    bit   ready;
    int   nDeq;
    ent_t e;
    ent_t nxt[$];
    logic [1:0] bp;
    bp          = 2'($urandom_range(0, 3));
    in_valid    = v;
    in_pc       = {p1, p0};
    in_inst     = {p1 ^ 32'hCAFE_0000, p0 ^ 32'hCAFE_0000};
    in_bp_taken = bp;
    deq         = d;
    flush       = f;
    #1;
    ready = (DEPTH - modelQ.size()) >= 2;
    incQ.delete();
    if (ready && !f) begin
      if (v[0]) begin e.pc = p0; e.inst = p0 ^ 32'hCAFE_0000; e.bp = bp[0]; incQ.push_back(e); end
      if (v[1]) begin e.pc = p1; e.inst = p1 ^ 32'hCAFE_0000; e.bp = bp[1]; incQ.push_back(e); end
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    visQ = {modelQ, incQ};
`else
    visQ = modelQ;
`endif
    checkOutput(ready);
    if (d == 2'b11)      nDeq = (visQ.size() >= 2) ? 2 : visQ.size();
    else if (d == 2'b01) nDeq = (visQ.size() >= 1) ? 1 : 0;
    else                 nDeq = 0;
    nxt = {modelQ, incQ};
    for (int i = 0; i < nDeq; i++) void'(nxt.pop_front());
    if (f) nxt.delete();
    @(posedge clk);
    #1;
    modelQ = nxt;
  endtask

  task automatic idleInputs();
    in_valid = '0; in_pc = '0; in_inst = '0; in_bp_taken = '0; deq = '0; flush = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{2'b11, 32'h00,  32'h04,  2'b00, 1'b0, 2};
    vecs[1]  = '{2'b11, 32'h08,  32'h0C,  2'b00, 1'b0, 4};
    vecs[2]  = '{2'b01, 32'h10,  32'hF0,  2'b00, 1'b0, 5};
    vecs[3]  = '{2'b11, 32'h14,  32'h18,  2'b00, 1'b0, 7};
    vecs[4]  = '{2'b11, 32'hEE0, 32'hEE4, 2'b00, 1'b0, 7};
    vecs[5]  = '{2'b10, 32'hEE8, 32'hEEC, 2'b10, 1'b0, 7};
    vecs[6]  = '{2'b00, 32'h0,   32'h0,   2'b01, 1'b0, 6};
    vecs[7]  = '{2'b01, 32'h1C,  32'hF4,  2'b00, 1'b0, 7};
    vecs[8]  = '{2'b00, 32'h0,   32'h0,   2'b11, 1'b0, 5};
    vecs[9]  = '{2'b00, 32'h0,   32'h0,   2'b11, 1'b0, 3};
    vecs[10] = '{2'b11, 32'h24,  32'h28,  2'b01, 1'b0, 4};
    vecs[11] = '{2'b00, 32'h0,   32'h0,   2'b11, 1'b0, 2};
    vecs[12] = '{2'b11, 32'h2C,  32'h30,  2'b11, 1'b0, 2};
    vecs[13] = '{2'b01, 32'h34,  32'hF8,  2'b01, 1'b0, 2};
    vecs[14] = '{2'b11, 32'h38,  32'h3C,  2'b00, 1'b0, 4};
    vecs[15] = '{2'b01, 32'h40,  32'hFC,  2'b00, 1'b0, 5};
    vecs[16] = '{2'b11, 32'h44,  32'h48,  2'b11, 1'b1, 0};
    vecs[17] = '{2'b10, 32'h99,  32'h14,  2'b00, 1'b0, 1};
    vecs[18] = '{2'b00, 32'h0,   32'h0,   2'b10, 1'b0, 1};
    vecs[19] = '{2'b00, 32'h0,   32'h0,   2'b11, 1'b0, 0};
    vecs[20] = '{2'b00, 32'h0,   32'h0,   2'b01, 1'b0, 0};

    rst = 1'b1;
    idleInputs();
    repeat (2) @(posedge clk);
    #1;
    modelQ.delete();
    visQ.delete();
    checkOutput(1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].v, vecs[i].p0, vecs[i].p1, vecs[i].d, vecs[i].f);
      expect32($sformatf("count_after_v%0d", i), 32'(count), 32'(vecs[i].expCount));
    end

`ifdef FETCH_QUEUE_BYPASS_EN
    applyStimulus(2'b11, 32'h50, 32'h54, 2'b01, 1'b0);
    expect32("bypass_count", 32'(count), 32'd1);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    expect32("bypass_hold", 32'(count), 32'd1);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b01, 1'b0);
`endif

    applyStimulus(2'b11, 32'h60, 32'h64, 2'b00, 1'b0);
    applyStimulus(2'b01, 32'h68, 32'h0,  2'b00, 1'b0);
    expect32("pre_reset_count", 32'(count), 32'd3);
    // Asynchronous reset landing mid-cycle, away from any clock edge.
    #2;
    rst = 1'b1;
    idleInputs();
    #1;
    modelQ.delete();
    visQ.delete();
    checkOutput(1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(2'b11, 32'h70, 32'h74, 2'b00, 1'b0);
    expect32("post_reset_count", 32'(count), 32'd2);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
    expect32("post_reset_drain", 32'(count), 32'd0);

    idleInputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 32, instruction/PC width.
REQ-002 SHALL have parameter DEPTH, default 8, queue entries; power of two, >=4.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  2  per-slot valid from fetch; slot 0 is the older instruction.
REQ-006 SHALL have port in_inst  input  2xWIDTH  fetched instructions.
REQ-007 SHALL have port in_pc  input  2xWIDTH  PC of each slot.
REQ-008 SHALL have port in_bp_taken  input  2  predictor decision per slot.
REQ-009 SHALL have port in_ready  output  1  high when free entries >=2; fetch stalls when low.
REQ-010 SHALL have port out_valid  output  2  decode-side valid; slot 0 is the oldest entry.
REQ-011 SHALL have ports out_inst, out_pc  output  2xWIDTH, and out_bp_taken  output  2, as head-entry views.
REQ-012 SHALL have port deq  input  2  decode consume mask; legal values 00, 01 and 11.
REQ-013 SHALL have port flush  input  1  branch correction; discard all contents.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  registered occupancy.

Function
REQ-015 SHALL enqueue only in cycles where in_ready=1 and flush=0; valid slots are written in order, and in_valid=10 is compacted to a single entry.
REQ-016 SHALL compute in_ready from the registered count only: DEPTH-count>=2, with no credit for same-cycle dequeue.
REQ-017 SHALL drive out_valid[0] when count>=1 and out_valid[1] when count>=2; slot k shows entry head+k modulo DEPTH.
REQ-018 SHALL pop deq[0]+deq[1] entries per cycle, where deq=10 is treated as 00 and deq bits without a matching out_valid are ignored.
REQ-019 SHALL update count as count+nenq-ndeq on simultaneous enqueue and dequeue; head and tail pointers wrap modulo DEPTH.
REQ-020 SHALL, on flush, make count, head and tail 0 at the next edge and discard that cycle's enqueue and dequeue.
REQ-021 SHALL drive out_inst, out_pc and out_bp_taken of a slot to 0 while that slot's out_valid is low.
REQ-022 SHALL, with bypass off, have a latency of 1 cycle from an entry being written at edge N to out_valid at N+1.
REQ-023 SHALL never overflow or underflow; count SHALL stay within 0..DEPTH.

Reset
REQ-024 SHALL, on rst, clear head, tail and count to 0, giving out_valid=00, in_ready=1 and all out data 0; the storage array is not reset.
REQ-025 SHALL treat rst asserted mid-operation exactly like REQ-024: all entries are lost and no partial update occurs.

Configuration
REQ-026 SHALL honour macro FETCH_QUEUE_BYPASS_EN; when defined, the output view is the queue entries followed by the compacted incoming entries (in_ready=1, flush=0), so an empty queue presents fetch data in the same cycle.
REQ-027 SHALL, with FETCH_QUEUE_BYPASS_EN defined, store only the incoming entries not consumed in that cycle, with ndeq <= count+nenq.
REQ-028 SHALL, when FETCH_QUEUE_BYPASS_EN is undefined, present only registered entries, per REQ-017 and REQ-022.

Structure
REQ-029 SHALL take from the shared core package the typedef fq_entry_t {inst, pc, bp_taken} and the constant FQ_DEPTH.
REQ-030 SHALL contain a single combinational sub-module, fq_slot_compactor, performing in_valid compaction into write count and ordered entries.

Verification
REQ-031 SHALL be verified by this scenario: after reset, in_valid=11 with pc 0x0/0x4 at edge 1 -> next cycle count=2, out_valid=11, out_pc=0x0/0x4 (bypass off).
REQ-032 SHALL be verified by this scenario: fill with DEPTH=8 and deq=00 -> in_ready drops when count=7, and count never exceeds 8.
REQ-033 SHALL be verified by this scenario: count=3, in_valid=11 and deq=01 in the same cycle -> count=4, and order is preserved across pointer wrap at index 7->0.
REQ-034 SHALL be verified by this scenario: in_valid=10 with pc 0x14 -> single entry, out_pc[0]=0x14, out_valid=01.
REQ-035 SHALL be verified by this scenario: flush with count=5 and simultaneous enqueue -> next cycle count=0, out_valid=00, in_ready=1.
REQ-036 SHALL be verified by this scenario: with bypass defined, empty queue, in_valid=11 and deq=01 -> out_pc[0] visible in the same cycle, and next cycle count=1 holding slot 1.
